// File: rtl/udlx_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : udlx_wb_pkg
// Purpose  : Shared definitions for the writeback stage: load size encodings
//            and register-file sizing.
// Revision : 1.0 - initial release
// ============================================================================
package udlx_wb_pkg;

  // Encoding of the memory access size carried with each load return.
  // The reserved code is handled as a full word.
  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10,
    LD_RSVD = 2'b11
  } ld_size_e;

  // Number of architectural registers for a given index width.
  function automatic int unsigned nregs(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Register count of the default five-bit register index.
  localparam int unsigned NREGS = nregs(5);

endpackage
`default_nettype wire

// File: rtl/load_extender.sv
`default_nettype none
// ============================================================================
// Module   : load_extender
// Purpose  : Selects the byte or halfword lane of a raw memory word and
//            zero- or sign-extends it to 32 bits. Words pass through.
//            Only instantiated when WB_LOAD_EXTEND_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module load_extender
  import udlx_wb_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  byte_off_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection: byte by full offset, halfword by the upper offset bit only.
  always_comb begin
    w_byte = 8'h00;
    case (byte_off_i)
      2'd0:    w_byte = data_i[7:0];
      2'd1:    w_byte = data_i[15:8];
      2'd2:    w_byte = data_i[23:16];
      default: w_byte = data_i[31:24];
    endcase
    w_half = byte_off_i[1] ? data_i[31:16] : data_i[15:0];
  end

  // Extension of the selected lane; reserved size behaves like a word.
  always_comb begin
    data_o = data_i;
    case (ld_size_e'(size_i))
      LD_BYTE: data_o = {{24{signed_i & w_byte[7]}}, w_byte};
      LD_HALF: data_o = {{16{signed_i & w_half[15]}}, w_half};
      default: data_o = data_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Final pipeline stage. Registers ALU results onto register-file
//            write port A and load returns onto port B. Tracks outstanding
//            loads per register so decode can stall on RAW hazards, and
//            squashes load returns overtaken by a younger ALU write.
//            Optional macro WB_LOAD_EXTEND_EN enables sub-word load lane
//            selection and extension (DATA_WIDTH must then be 32).
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage
  import udlx_wb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]    alu_data_i,
  input  logic                     ld_issue_i,
  input  logic [ADDRESS_WIDTH-1:0] ld_issue_addr_i,
  input  logic                     ld_valid_i,
  output logic                     ld_ready_o,
  input  logic [ADDRESS_WIDTH-1:0] ld_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]    ld_data_i,
  input  logic [1:0]               ld_size_i,
  input  logic                     ld_signed_i,
  input  logic [1:0]               ld_byte_off_i,
  input  logic [ADDRESS_WIDTH-1:0] rd_reg1_addr_i,
  input  logic [ADDRESS_WIDTH-1:0] rd_reg2_addr_i,
  output logic                     rd_stall_o,
  output logic                     reg_a_wr_en_o,
  output logic [ADDRESS_WIDTH-1:0] reg_a_wr_addr_o,
  output logic [DATA_WIDTH-1:0]    reg_a_wr_data_o,
  output logic                     reg_b_wr_en_o,
  output logic [ADDRESS_WIDTH-1:0] reg_b_wr_addr_o,
  output logic [DATA_WIDTH-1:0]    reg_b_wr_data_o
);

  localparam int unsigned c_NREGS = nregs(ADDRESS_WIDTH);

  logic                     ld_ready_q;
  logic                     a_en_q;
  logic [ADDRESS_WIDTH-1:0] a_addr_q;
  logic [DATA_WIDTH-1:0]    a_data_q;
  logic                     b_en_q;
  logic [ADDRESS_WIDTH-1:0] b_addr_q;
  logic [DATA_WIDTH-1:0]    b_data_q;
  logic [c_NREGS-1:0]       pending_q, pending_d;
  logic [c_NREGS-1:0]       kill_q, kill_d;

  logic                     w_ld_xfer;
  logic                     w_a_wr;
  logic                     w_b_wr;
  logic [DATA_WIDTH-1:0]    w_ld_data;

  // Load return data formatting.
`ifdef WB_LOAD_EXTEND_EN
  load_extender u_load_extender (
    .data_i     (ld_data_i),
    .size_i     (ld_size_i),
    .signed_i   (ld_signed_i),
    .byte_off_i (ld_byte_off_i),
    .data_o     (w_ld_data)
  );
`else
  // Size/sign/offset carry no meaning without extension; fold them into a sink.
  logic unused_ld_fmt;
  assign unused_ld_fmt = ^{ld_size_i, ld_signed_i, ld_byte_off_i};
  assign w_ld_data     = ld_data_i;
`endif

  assign w_ld_xfer = ld_valid_i & ld_ready_q;
  assign w_a_wr    = alu_valid_i & (alu_rd_addr_i != '0);
  // Port B writes unless r0, killed by an earlier younger ALU write, or
  // colliding with an ALU write to the same register in this very cycle.
  assign w_b_wr    = w_ld_xfer & (ld_rd_addr_i != '0) & ~kill_q[ld_rd_addr_i]
                   & ~(alu_valid_i & (alu_rd_addr_i == ld_rd_addr_i));

  // Decode hazard query; r0 can never be pending so needs no special case.
  assign rd_stall_o = pending_q[rd_reg1_addr_i] | pending_q[rd_reg2_addr_i];

  // Scoreboard next state: later statements override, giving issue > return > ALU kill.
  always_comb begin
    pending_d = pending_q;
    kill_d    = kill_q;
    if (alu_valid_i && pending_q[alu_rd_addr_i]) begin
      kill_d[alu_rd_addr_i] = 1'b1;
    end
    if (w_ld_xfer) begin
      pending_d[ld_rd_addr_i] = 1'b0;
      kill_d[ld_rd_addr_i]    = 1'b0;
    end
    if (ld_issue_i && (ld_issue_addr_i != '0)) begin
      pending_d[ld_issue_addr_i] = 1'b1;
      kill_d[ld_issue_addr_i]    = 1'b0;
    end
  end

  // Scoreboard state and load-ready handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      kill_q     <= '0;
      ld_ready_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      kill_q     <= kill_d;
      ld_ready_q <= 1'b1;
    end
  end

  // Write port A: ALU results, one cycle after presentation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_en_q   <= 1'b0;
      a_addr_q <= '0;
      a_data_q <= '0;
    end else begin
      a_en_q <= w_a_wr;
      if (alu_valid_i) begin
        a_addr_q <= alu_rd_addr_i;
        a_data_q <= alu_data_i;
      end
    end
  end

  // Write port B: accepted load returns, one cycle after transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_en_q   <= 1'b0;
      b_addr_q <= '0;
      b_data_q <= '0;
    end else begin
      b_en_q <= w_b_wr;
      if (w_ld_xfer) begin
        b_addr_q <= ld_rd_addr_i;
        b_data_q <= w_ld_data;
      end
    end
  end

  assign ld_ready_o      = ld_ready_q;
  assign reg_a_wr_en_o   = a_en_q;
  assign reg_a_wr_addr_o = a_addr_q;
  assign reg_a_wr_data_o = a_data_q;
  assign reg_b_wr_en_o   = b_en_q;
  assign reg_b_wr_addr_o = b_addr_q;
  assign reg_b_wr_data_o = b_data_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Self-checking bench for writeback_stage: vector table driven
//            through a scoreboard queue, plus reset and extension sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd_addr;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_addr;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd_addr;
  logic [31:0] ld_data;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic [1:0]  ld_byte_off;
  logic [4:0]  rd_reg1_addr;
  logic [4:0]  rd_reg2_addr;
  logic        rd_stall;
  logic        a_en, b_en;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  writeback_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid_i     (alu_valid),
    .alu_rd_addr_i   (alu_rd_addr),
    .alu_data_i      (alu_data),
    .ld_issue_i      (ld_issue),
    .ld_issue_addr_i (ld_issue_addr),
    .ld_valid_i      (ld_valid),
    .ld_ready_o      (ld_ready),
    .ld_rd_addr_i    (ld_rd_addr),
    .ld_data_i       (ld_data),
    .ld_size_i       (ld_size),
    .ld_signed_i     (ld_signed),
    .ld_byte_off_i   (ld_byte_off),
    .rd_reg1_addr_i  (rd_reg1_addr),
    .rd_reg2_addr_i  (rd_reg2_addr),
    .rd_stall_o      (rd_stall),
    .reg_a_wr_en_o   (a_en),
    .reg_a_wr_addr_o (a_addr),
    .reg_a_wr_data_o (a_data),
    .reg_b_wr_en_o   (b_en),
    .reg_b_wr_addr_o (b_addr),
    .reg_b_wr_data_o (b_data)
  );

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_a;
    logic [31:0] alu_d;
    logic        iss;
    logic [4:0]  iss_a;
    logic        ld_v;
    logic [4:0]  ld_a;
    logic [31:0] ld_d;
    logic [1:0]  sz;
    logic        sg;
    logic [1:0]  off;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        exp_stall;
    logic        exp_a_en;
    logic        exp_b_en;
    logic [31:0] exp_b_d;
  } vec_t;

  typedef struct {
    logic        a_en;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_en;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[19];

  function automatic vec_t mk(input logic alu_v, input logic [4:0] alu_a,
                              input logic [31:0] alu_d, input logic iss,
                              input logic [4:0] iss_a, input logic ld_v,
                              input logic [4:0] ld_a, input logic [31:0] ld_d,
                              input logic [4:0] q1, input logic [4:0] q2,
                              input logic es, input logic ea, input logic eb);
    vec_t v;
    v.alu_v = alu_v; v.alu_a = alu_a; v.alu_d = alu_d;
    v.iss = iss; v.iss_a = iss_a;
    v.ld_v = ld_v; v.ld_a = ld_a; v.ld_d = ld_d;
    v.sz = 2'b10; v.sg = 1'b0; v.off = 2'b00;
    v.q1 = q1; v.q2 = q2;
    v.exp_stall = es; v.exp_a_en = ea; v.exp_b_en = eb;
    v.exp_b_d = ld_d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd_addr = 0; alu_data = 0;
    ld_issue = 0; ld_issue_addr = 0;
    ld_valid = 0; ld_rd_addr = 0; ld_data = 0;
    ld_size = 2'b10; ld_signed = 0; ld_byte_off = 0;
    rd_reg1_addr = 0; rd_reg2_addr = 0;
  endtask

  // Drive one vector at the falling edge, check the hazard query, queue the
  // expected write-port state and compare it just after the rising edge.
  task automatic drive_vec(input vec_t v, input string tag);
    exp_t e, got;
    @(negedge clk);
    alu_valid = v.alu_v; alu_rd_addr = v.alu_a; alu_data = v.alu_d;
    ld_issue = v.iss; ld_issue_addr = v.iss_a;
    ld_valid = v.ld_v; ld_rd_addr = v.ld_a; ld_data = v.ld_d;
    ld_size = v.sz; ld_signed = v.sg; ld_byte_off = v.off;
    rd_reg1_addr = v.q1; rd_reg2_addr = v.q2;
    #1;
    chk({tag, " rd_stall"}, {31'd0, rd_stall}, {31'd0, v.exp_stall});
    e.a_en = v.exp_a_en; e.a_addr = v.alu_a; e.a_data = v.alu_d;
    e.b_en = v.exp_b_en; e.b_addr = v.ld_a;  e.b_data = v.exp_b_d;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({tag, " a_en"}, {31'd0, a_en}, {31'd0, got.a_en});
    if (got.a_en) begin
      chk({tag, " a_addr"}, {27'd0, a_addr}, {27'd0, got.a_addr});
      chk({tag, " a_data"}, a_data, got.a_data);
    end
    chk({tag, " b_en"}, {31'd0, b_en}, {31'd0, got.b_en});
    if (got.b_en) begin
      chk({tag, " b_addr"}, {27'd0, b_addr}, {27'd0, got.b_addr});
      chk({tag, " b_data"}, b_data, got.b_data);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " a_en"},     {31'd0, a_en},     32'd0);
    chk({tag, " a_addr"},   {27'd0, a_addr},   32'd0);
    chk({tag, " a_data"},   a_data,            32'd0);
    chk({tag, " b_en"},     {31'd0, b_en},     32'd0);
    chk({tag, " b_addr"},   {27'd0, b_addr},   32'd0);
    chk({tag, " b_data"},   b_data,            32'd0);
    chk({tag, " ld_ready"}, {31'd0, ld_ready}, 32'd0);
    chk({tag, " rd_stall"}, {31'd0, rd_stall}, 32'd0);
  endtask

  initial begin
    vec_t v;
    //              alu_v a   data          iss a  ld_v a   data          q1 q2 st ae be
    vecs[0]  = mk(1, 5,  32'h0000_1234, 0, 0, 0, 0,  32'h0,         0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 0,  32'hDEAD_BEEF, 0, 0, 0, 0,  32'h0,         0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0,  32'h0,         1, 7, 0, 0,  32'h0,         7, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0,  32'h0,         0, 0, 0, 0,  32'h0,         7, 0, 1, 0, 0);
    vecs[4]  = mk(1, 6,  32'h0000_0066, 0, 0, 0, 0,  32'h0,         0, 7, 1, 1, 0);
    vecs[5]  = mk(0, 0,  32'h0,         0, 0, 1, 7,  32'h0000_CAFE, 7, 0, 1, 0, 1);
    vecs[6]  = mk(0, 0,  32'h0,         0, 0, 0, 0,  32'h0,         7, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0,  32'h0,         1, 3, 0, 0,  32'h0,         0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 3,  32'h0000_0011, 0, 0, 0, 0,  32'h0,         3, 0, 1, 1, 0);
    vecs[9]  = mk(0, 0,  32'h0,         0, 0, 1, 3,  32'h0000_0022, 3, 0, 1, 0, 0);
    vecs[10] = mk(0, 0,  32'h0,         0, 0, 0, 0,  32'h0,         3, 0, 0, 0, 0);
    vecs[11] = mk(0, 0,  32'h0,         1, 9, 1, 9,  32'h0000_0099, 0, 0, 0, 0, 1);
    vecs[12] = mk(0, 0,  32'h0,         0, 0, 0, 0,  32'h0,         9, 0, 1, 0, 0);
    vecs[13] = mk(0, 0,  32'h0,         0, 0, 1, 9,  32'h0000_009A, 9, 0, 1, 0, 1);
    vecs[14] = mk(0, 0,  32'h0,         0, 0, 0, 0,  32'h0,         0, 9, 0, 0, 0);
    vecs[15] = mk(0, 0,  32'h0,         1, 0, 0, 0,  32'h0,         0, 0, 0, 0, 0);
    vecs[16] = mk(1, 4,  32'h0000_0044, 0, 0, 1, 4,  32'h0000_0045, 0, 0, 0, 1, 0);
    vecs[17] = mk(0, 0,  32'h0,         0, 0, 1, 12, 32'h0000_0012, 0, 0, 0, 0, 1);
    vecs[18] = mk(0, 0,  32'h0,         0, 0, 1, 0,  32'h0000_0F00, 0, 0, 0, 0, 0);

    idle_inputs();
    rst = 1'b1;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ld_ready after reset", {31'd0, ld_ready}, 32'd1);

    for (int i = 0; i < 19; i++) begin
      drive_vec(vecs[i], $sformatf("vec%0d", i));
    end

`ifdef WB_LOAD_EXTEND_EN
    v = mk(0, 0, 32'h0, 0, 0, 1, 10, 32'h80FF_7F01, 0, 0, 0, 0, 1);
    v.sz = 2'b00; v.sg = 1'b1; v.off = 2'd3; v.exp_b_d = 32'hFFFF_FF80;
    drive_vec(v, "ext byte signed off3");
    v.sz = 2'b01; v.sg = 1'b0; v.off = 2'd2; v.exp_b_d = 32'h0000_80FF;
    drive_vec(v, "ext half unsigned off2");
    v.sz = 2'b00; v.sg = 1'b1; v.off = 2'd0; v.exp_b_d = 32'h0000_0001;
    drive_vec(v, "ext byte signed off0");
    v.sz = 2'b01; v.sg = 1'b1; v.off = 2'd2; v.exp_b_d = 32'hFFFF_80FF;
    drive_vec(v, "ext half signed off2");
    v.sz = 2'b11; v.sg = 1'b1; v.off = 2'd1; v.exp_b_d = 32'h80FF_7F01;
    drive_vec(v, "ext reserved size");
`else
    v = mk(0, 0, 32'h0, 0, 0, 1, 10, 32'h80FF_7F01, 0, 0, 0, 0, 1);
    v.sz = 2'b00; v.sg = 1'b1; v.off = 2'd3;
    drive_vec(v, "raw byte passthrough");
`endif

    // Four loads outstanding, r2 killed by a younger ALU write, then reset.
    drive_vec(mk(0, 0, 32'h0, 1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0), "pend r1");
    drive_vec(mk(0, 0, 32'h0, 1, 2, 0, 0, 32'h0, 0, 0, 0, 0, 0), "pend r2");
    drive_vec(mk(0, 0, 32'h0, 1, 3, 0, 0, 32'h0, 0, 0, 0, 0, 0), "pend r3");
    drive_vec(mk(0, 0, 32'h0, 1, 4, 0, 0, 32'h0, 0, 0, 0, 0, 0), "pend r4");
    drive_vec(mk(1, 2, 32'h0000_0002, 0, 0, 0, 0, 32'h0, 1, 4, 1, 1, 0), "kill r2");
    idle_inputs();
    rd_reg1_addr = 5'd3;
    rd_reg2_addr = 5'd4;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ld_ready after mid reset", {31'd0, ld_ready}, 32'd1);
    drive_vec(mk(0, 0, 32'h0, 0, 0, 1, 2, 32'h0000_2222, 2, 1, 0, 0, 1), "post-reset ret r2");
    drive_vec(mk(0, 0, 32'h0, 0, 0, 1, 1, 32'h0000_1111, 3, 4, 0, 0, 1), "post-reset ret r1");

    if (sb_q.size() != 0) begin
      chk("scoreboard drained", sb_q.size(), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
